rtc_responder: RTL and testbench
================================

RTC_RESPONDER -- requirements
Module: rtc_responder

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ad, input, 1 bit: active-low address strobe from the bus master.
REQ-004 SHALL have ports cs, wr and rd, inputs, 1 bit each: active-low chip select, write strobe and read strobe.
REQ-005 SHALL have port ADin, input, 8 bits: multiplexed address/data driven by the master.
REQ-006 SHALL have port ADout, output, 8 bits: read data returned to the master.
REQ-007 SHALL have port oe, output, 1 bit: high while ADout carries valid read data.
REQ-008 SHALL have port tick, input, 1 bit: one-clock pulse per elapsed second.
REQ-009 SHALL have port busy, output, 1 bit: high while cs is low (synchronized).

Function
REQ-010 SHALL pass ad, cs, wr, rd and ADin through a 2-flop synchronizer; all decoding SHALL use the synchronized copies, so ADin is sampled aligned with its strobes.
REQ-011 SHALL latch address register addr on a synchronized wr rising edge seen with cs=0 and ad=0.
REQ-012 SHALL treat a wr rising edge with cs=0 and ad=1 as a data write of synchronized ADin to register addr.
REQ-013 SHALL, while cs=0, ad=1 and rd=0 (synchronized), drive ADout = contents of addr and oe=1 no later than 3 clocks after the raw rd falls.
REQ-014 SHALL, when rd or cs returns high (synchronized), force oe=0 and ADout=8'hFF on the next clock.
REQ-015 SHALL implement register map: 0x00 control (bit4 = 12-hour mode, other bits R/W storage), 0x21 seconds, 0x22 minutes, 0x23 hours, 0x24 weekday; all time values in BCD.
REQ-016 SHALL return 8'h00 on reads of unmapped addresses and ignore writes to them.
REQ-017 SHALL mask writes: seconds/minutes bit7=0; weekday bits7:3=0; hours bit6=0.
REQ-018 SHALL, on each applied tick, increment seconds 00..59; on wrap to 00, increment minutes 00..59; on wrap to 00, increment hours.
REQ-019 SHALL, in 24-hour mode, count hours 00..23; a wrap to 00 SHALL increment weekday 1..7, with 7 wrapping to 1.
REQ-020 SHALL, in 12-hour mode, count hours[6:0] 01..12, with bit7 = PM: 11 to 12 toggles bit7; 12 to 01 leaves it unchanged; the PM-to-AM toggle (11 PM to 12 AM) increments weekday.
REQ-021 SHALL hold a tick that arrives while busy=1 in a single pending flag and apply it on the first clock with busy=0; further ticks during the same busy window SHALL be dropped.
REQ-022 SHALL give a bus write priority over a same-clock tick increment; that tick SHALL become pending.
REQ-023 SHALL store invalid BCD exactly as written; the increment SHALL treat any value at or above its limit as the wrap point.
REQ-024 SHALL abandon a phase (no write, oe=0) when cs rises before the wr edge.

Reset
REQ-025 SHALL, while reset=0, hold: ADout=8'hFF, oe=0, busy=0, addr=8'hFF, control=8'h00, seconds=8'h00, minutes=8'h00, hours=8'h00 (24-hour mode), weekday=8'h01, pending=0, synchronizers=1 (idle-high), ADin synchronizer=8'hFF.
REQ-026 SHALL, on reset assertion mid-transfer, drop oe immediately (asynchronously); it SHALL ignore the interrupted transfer after release.

Structure
REQ-027 SHALL place register addresses (0x00, 0x21..0x24), the control bit index and the BCD limits in a shared package, rtc_pkg.
REQ-028 SHALL implement BCD increment-with-wrap (value, min, max -> next, carry) as one sub-module, bcd_inc, instantiated per time field.

Verification
REQ-029 SHALL cover: address 0x22 phase, then write 0x45 -> a later read of 0x22 returns 0x45 with oe=1 within 3 clocks of rd low.
REQ-030 SHALL cover: seconds=0x59, minutes=0x59, hours=0x23, weekday=7 in 24-hour mode, one tick -> 0x00/0x00/0x00/weekday 1.
REQ-031 SHALL cover: 12-hour mode, hours=0x11 (AM), minutes=seconds=0x59, tick -> hours=0x92; next full hour -> 0x81.
REQ-032 SHALL cover: tick pulsed while cs=0 during a read of 0x21 (0x10) -> read returns 0x10; seconds=0x11 one clock after cs rises.
REQ-033 SHALL cover: read of address 0x50 -> ADout=0x00; a write to 0x50 leaves all registers unchanged.
REQ-034 SHALL cover: reset asserted while oe=1 -> oe=0 and ADout=0xFF with no clock edge, registers at their reset values.

Source files
------------

// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared constants and types for the RTC bus responder:
//               register map, control bit index, BCD limits, write masks
//               and the strobe bundle carried through the synchronizer.
// Revision    : 1.0  initial release
// ============================================================================
package rtc_pkg;

  // Register map
  localparam logic [7:0] c_ADDR_CTRL  = 8'h00;
  localparam logic [7:0] c_ADDR_SEC   = 8'h21;
  localparam logic [7:0] c_ADDR_MIN   = 8'h22;
  localparam logic [7:0] c_ADDR_HOUR  = 8'h23;
  localparam logic [7:0] c_ADDR_WDAY  = 8'h24;

  // Control register: bit set selects 12-hour counting
  localparam int         c_CTRL_12H_BIT = 4;
  // Hours register in 12-hour mode: PM flag position
  localparam int         c_HOUR_PM_BIT  = 7;

  // BCD limits (min, max) per field
  localparam logic [7:0] c_BCD_ZERO     = 8'h00;
  localparam logic [7:0] c_SEC_MAX      = 8'h59;
  localparam logic [7:0] c_MIN_MAX      = 8'h59;
  localparam logic [7:0] c_HOUR24_MAX   = 8'h23;
  localparam logic [7:0] c_HOUR12_MIN   = 8'h01;
  localparam logic [7:0] c_HOUR12_MAX   = 8'h12;
  localparam logic [7:0] c_WDAY_MIN     = 8'h01;
  localparam logic [7:0] c_WDAY_MAX     = 8'h07;

  // Bits that writes are allowed to set
  localparam logic [7:0] c_SEC_WMASK    = 8'h7F;
  localparam logic [7:0] c_MIN_WMASK    = 8'h7F;
  localparam logic [7:0] c_HOUR_WMASK   = 8'hBF;
  localparam logic [7:0] c_WDAY_WMASK   = 8'h07;

  // Read data values
  localparam logic [7:0] c_UNMAPPED_RDATA = 8'h00;
  localparam logic [7:0] c_IDLE_RDATA     = 8'hFF;

  // Active-low bus strobes, synchronized as one bundle
  typedef struct packed {
    logic ad;
    logic cs;
    logic wr;
    logic rd;
  } strobes_t;

  localparam strobes_t c_STROBES_IDLE = '{ad: 1'b1, cs: 1'b1, wr: 1'b1, rd: 1'b1};

endpackage : rtc_pkg
`default_nettype wire

// File: rtl/rtc_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_responder_if
// Description : Bus between a master and the RTC responder.
//   ad, cs, wr, rd : active-low strobes driven by the master
//   ADin           : multiplexed address/data from the master
//   ADout, oe      : read data and its valid flag from the responder
//   tick           : one-clock pulse per elapsed second
//   busy           : responder is selected (synchronized cs low)
// Revision    : 1.0  initial release
// ============================================================================
interface rtc_responder_if;
  logic       ad;
  logic       cs;
  logic       wr;
  logic       rd;
  logic [7:0] ADin;
  logic [7:0] ADout;
  logic       oe;
  logic       tick;
  logic       busy;

  modport master (output ad, cs, wr, rd, ADin, tick,
                  input  ADout, oe, busy);
  modport slave  (input  ad, cs, wr, rd, ADin, tick,
                  output ADout, oe, busy);
endinterface : rtc_responder_if
`default_nettype wire

// File: rtl/bcd_inc.sv
`default_nettype none
// ============================================================================
// Module      : bcd_inc
// Description : Combinational two-digit BCD increment with wrap.
//   i_value : current field value
//   i_min   : value loaded on wrap
//   i_max   : wrap point; any value at or above it wraps
//   o_next  : incremented (or wrapped) value
//   o_carry : high when the field wrapped
// Revision    : 1.0  initial release
// ============================================================================
module bcd_inc (
  input  logic [7:0] i_value,
  input  logic [7:0] i_min,
  input  logic [7:0] i_max,
  output logic [7:0] o_next,
  output logic       o_carry
);

  always_comb begin
    o_next  = i_value;
    o_carry = 1'b0;
    if (i_value >= i_max) begin
      // Invalid BCD above the limit also lands here and wraps cleanly
      o_next  = i_min;
      o_carry = 1'b1;
    end else if (i_value[3:0] >= 4'd9) begin
      o_next  = {i_value[7:4] + 4'd1, 4'd0};
    end else begin
      o_next  = {i_value[7:4], i_value[3:0] + 4'd1};
    end
  end

endmodule : bcd_inc
`default_nettype wire

// File: rtl/rtc_responder.sv
`default_nettype none
// ============================================================================
// Module      : rtc_responder
// Description : Real-time-clock register file on an asynchronous
//               multiplexed address/data bus. Keeps BCD seconds, minutes,
//               hours (24- or 12-hour) and weekday, advanced by tick.
//   clock : rising-edge clock for all state
//   reset : asynchronous active-low reset
//   bus   : slave side of rtc_responder_if (strobes, ADin, ADout, oe,
//           tick, busy)
// Revision    : 1.0  initial release
// ============================================================================
module rtc_responder
  import rtc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  rtc_responder_if.slave   bus
);

  // Two-flop synchronizers; ADin travels with its strobes so data is
  // aligned with the synchronized wr edge.
  strobes_t   r_strb_s1, r_strb_s2;
  logic [7:0] r_adin_s1, r_adin_s2;
  logic       r_wr_d;

  logic [7:0] r_addr;
  logic [7:0] r_ctrl;
  logic [7:0] r_sec;
  logic [7:0] r_min;
  logic [7:0] r_hour;
  logic [7:0] r_wday;
  logic       r_pending;
  logic [7:0] r_adout;
  logic       r_oe;

  logic       w_sel;
  logic       w_wr_rise;
  logic       w_addr_wr;
  logic       w_data_wr;
  logic       w_rd_active;
  logic       w_apply;
  logic       w_mode12;
  logic [7:0] w_rdata;

  logic [7:0] w_sec_next, w_min_next, w_h24_next, w_h12_next, w_wday_next;
  logic       w_sec_carry, w_min_carry, w_h24_carry, w_h12_carry, w_wday_carry;
  logic [7:0] w_hour_next;
  logic       w_day_roll;
  logic       w_pm_toggle;
  logic [1:0] w_unused_bits;

  assign w_sel       = ~r_strb_s2.cs;
  assign w_wr_rise   = r_strb_s2.wr & ~r_wr_d;
  assign w_addr_wr   = w_wr_rise & w_sel & ~r_strb_s2.ad;
  assign w_data_wr   = w_wr_rise & w_sel &  r_strb_s2.ad;
  assign w_rd_active = w_sel & r_strb_s2.ad & ~r_strb_s2.rd;
  // Ticks only advance time while the bus is not selected
  assign w_apply     = ~w_sel & (r_pending | bus.tick);
  assign w_mode12    = r_ctrl[c_CTRL_12H_BIT];

  assign bus.ADout = r_adout;
  assign bus.oe    = r_oe;
  assign bus.busy  = w_sel;

  // Read mux
  always_comb begin
    w_rdata = c_UNMAPPED_RDATA;
    case (r_addr)
      c_ADDR_CTRL: w_rdata = r_ctrl;
      c_ADDR_SEC:  w_rdata = r_sec;
      c_ADDR_MIN:  w_rdata = r_min;
      c_ADDR_HOUR: w_rdata = r_hour;
      c_ADDR_WDAY: w_rdata = r_wday;
      default:     w_rdata = c_UNMAPPED_RDATA;
    endcase
  end

  bcd_inc u_sec (
    .i_value (r_sec),      .i_min (c_BCD_ZERO),   .i_max (c_SEC_MAX),
    .o_next  (w_sec_next), .o_carry (w_sec_carry)
  );

  bcd_inc u_min (
    .i_value (r_min),      .i_min (c_BCD_ZERO),   .i_max (c_MIN_MAX),
    .o_next  (w_min_next), .o_carry (w_min_carry)
  );

  bcd_inc u_hour24 (
    .i_value (r_hour),     .i_min (c_BCD_ZERO),   .i_max (c_HOUR24_MAX),
    .o_next  (w_h24_next), .o_carry (w_h24_carry)
  );

  // 12-hour counting ignores the PM flag; it is handled below
  bcd_inc u_hour12 (
    .i_value ({1'b0, r_hour[6:0]}), .i_min (c_HOUR12_MIN), .i_max (c_HOUR12_MAX),
    .o_next  (w_h12_next),          .o_carry (w_h12_carry)
  );

  bcd_inc u_wday (
    .i_value (r_wday),      .i_min (c_WDAY_MIN),  .i_max (c_WDAY_MAX),
    .o_next  (w_wday_next), .o_carry (w_wday_carry)
  );

  assign w_unused_bits = {w_h12_next[7], w_wday_carry};

  // Hour roll: in 12-hour mode the PM flag flips on the 11 -> 12 step,
  // and a new day starts when that flip goes PM -> AM.
  always_comb begin
    w_pm_toggle = 1'b0;
    w_hour_next = w_h24_next;
    w_day_roll  = w_h24_carry;
    if (w_mode12) begin
      w_pm_toggle = ~w_h12_carry & (w_h12_next == c_HOUR12_MAX);
      w_hour_next = {r_hour[c_HOUR_PM_BIT] ^ w_pm_toggle, w_h12_next[6:0]};
      w_day_roll  = w_pm_toggle & r_hour[c_HOUR_PM_BIT];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_strb_s1 <= c_STROBES_IDLE;
      r_strb_s2 <= c_STROBES_IDLE;
      r_adin_s1 <= 8'hFF;
      r_adin_s2 <= 8'hFF;
      r_wr_d    <= 1'b1;
      r_addr    <= 8'hFF;
      r_ctrl    <= 8'h00;
      r_sec     <= 8'h00;
      r_min     <= 8'h00;
      r_hour    <= 8'h00;
      r_wday    <= 8'h01;
      r_pending <= 1'b0;
      r_adout   <= c_IDLE_RDATA;
      r_oe      <= 1'b0;
    end else begin
      r_strb_s1 <= '{ad: bus.ad, cs: bus.cs, wr: bus.wr, rd: bus.rd};
      r_strb_s2 <= r_strb_s1;
      r_adin_s1 <= bus.ADin;
      r_adin_s2 <= r_adin_s1;
      r_wr_d    <= r_strb_s2.wr;

      // One pending slot per busy window. A fresh tick on the very clock
      // the pending one is applied is kept for the following clock.
      if (w_sel) begin
        r_pending <= r_pending | bus.tick;
      end else begin
        r_pending <= r_pending & bus.tick;
      end

      if (w_addr_wr) begin
        r_addr <= r_adin_s2;
      end

      if (w_data_wr) begin
        case (r_addr)
          c_ADDR_CTRL: r_ctrl <= r_adin_s2;
          c_ADDR_SEC:  r_sec  <= r_adin_s2 & c_SEC_WMASK;
          c_ADDR_MIN:  r_min  <= r_adin_s2 & c_MIN_WMASK;
          c_ADDR_HOUR: r_hour <= r_adin_s2 & c_HOUR_WMASK;
          c_ADDR_WDAY: r_wday <= r_adin_s2 & c_WDAY_WMASK;
          default: ;
        endcase
      end else if (w_apply) begin
        r_sec <= w_sec_next;
        if (w_sec_carry) begin
          r_min <= w_min_next;
          if (w_min_carry) begin
            r_hour <= w_hour_next;
            if (w_day_roll) begin
              r_wday <= w_wday_next;
            end
          end
        end
      end

      if (w_rd_active) begin
        r_oe    <= 1'b1;
        r_adout <= w_rdata;
      end else begin
        r_oe    <= 1'b0;
        r_adout <= c_IDLE_RDATA;
      end
    end
  end

endmodule : rtc_responder
`default_nettype wire

// File: tb/tb_rtc_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_responder
// Description : Self-checking bench for rtc_responder. Stimulus pushes the
//               hand-computed read value into a queue; a monitor pops and
//               compares on each oe rising edge and checks read latency and
//               the idle bus value when oe drops.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rtc_responder;

  logic clock;
  logic reset;

  rtc_responder_if bus ();

  rtc_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_oe = 1'b0;
  int         rd_low_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  // Cycles since raw rd fell
  always @(posedge clock) begin
    if (bus.rd) rd_low_cnt <= 0;
    else        rd_low_cnt <= rd_low_cnt + 1;
  end

  // Monitor
  always @(negedge clock) begin : monitor
    logic [7:0] e;
    if (bus.oe && !prev_oe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %02h required no read", bus.ADout);
      end else begin
        e = exp_q.pop_front();
        check8("read_data", bus.ADout, e);
        checks++;
        if (rd_low_cnt < 1 || rd_low_cnt > 3) begin
          errors++;
          $display("FAIL read_latency: got %0d clocks required 1..3", rd_low_cnt);
        end
      end
    end
    if (!bus.oe && prev_oe) begin
      check8("idle_adout", bus.ADout, 8'hFF);
    end
    prev_oe <= bus.oe;
  end

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic addr_phase(input logic [7:0] a);
    bus.cs = 1'b0; bus.ad = 1'b0; bus.ADin = a;
    clk(3); bus.wr = 1'b0;
    clk(3); bus.wr = 1'b1;
    clk(3); bus.ad = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr_phase(a);
    bus.ADin = d;
    clk(3); bus.wr = 1'b0;
    clk(3); bus.wr = 1'b1;
    clk(3); bus.cs = 1'b1;
    clk(4);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp);
    addr_phase(a);
    clk(2);
    exp_q.push_back(exp);
    bus.rd = 1'b0;
    clk(6); bus.rd = 1'b1;
    clk(3); bus.cs = 1'b1;
    clk(4);
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    clk(1); bus.tick = 1'b0;
    clk(3);
  endtask

  initial begin
    bus.ad = 1'b1; bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b1;
    bus.ADin = 8'hFF; bus.tick = 1'b0;
    reset = 1'b0;
    clk(3);
    check8("reset_oe",    {7'd0, bus.oe},   8'h00);
    check8("reset_adout", bus.ADout,        8'hFF);
    check8("reset_busy",  {7'd0, bus.busy}, 8'h00);
    reset = 1'b1;
    clk(3);

    // Reset values through the bus
    bus_read(8'h00, 8'h00);
    bus_read(8'h21, 8'h00);
    bus_read(8'h24, 8'h01);

    // Basic write/read
    bus_write(8'h22, 8'h45);
    bus_read (8'h22, 8'h45);

    // Write masks and control storage
    bus_write(8'h21, 8'hFF); bus_read(8'h21, 8'h7F);
    bus_write(8'h24, 8'hFF); bus_read(8'h24, 8'h07);
    bus_write(8'h23, 8'hFF); bus_read(8'h23, 8'hBF);
    bus_write(8'h00, 8'hEF); bus_read(8'h00, 8'hEF);

    // 24-hour end of week rollover
    bus_write(8'h00, 8'h00);
    bus_write(8'h21, 8'h59); bus_write(8'h22, 8'h59);
    bus_write(8'h23, 8'h23); bus_write(8'h24, 8'h07);
    pulse_tick();
    bus_read(8'h21, 8'h00); bus_read(8'h22, 8'h00);
    bus_read(8'h23, 8'h00); bus_read(8'h24, 8'h01);

    // 12-hour: 11 AM -> 12 PM, 12 PM -> 1 PM, 11 PM -> 12 AM
    bus_write(8'h00, 8'h10);
    bus_write(8'h23, 8'h11); bus_write(8'h22, 8'h59); bus_write(8'h21, 8'h59);
    pulse_tick();
    bus_read(8'h23, 8'h92); bus_read(8'h22, 8'h00); bus_read(8'h21, 8'h00);
    bus_write(8'h22, 8'h59); bus_write(8'h21, 8'h59);
    pulse_tick();
    bus_read(8'h23, 8'h81); bus_read(8'h24, 8'h01);
    bus_write(8'h23, 8'h91); bus_write(8'h22, 8'h59); bus_write(8'h21, 8'h59);
    pulse_tick();
    bus_read(8'h23, 8'h12); bus_read(8'h24, 8'h02);

    // Ticks during a read are deferred; a second one in the window is dropped
    bus_write(8'h21, 8'h10);
    addr_phase(8'h21);
    clk(2);
    exp_q.push_back(8'h10);
    bus.rd = 1'b0;
    clk(2); bus.tick = 1'b1;
    clk(1); bus.tick = 1'b0;
    clk(1); bus.tick = 1'b1;
    clk(1); bus.tick = 1'b0;
    clk(2); bus.rd = 1'b1;
    clk(3); bus.cs = 1'b1;
    clk(4);
    bus_read(8'h21, 8'h11);

    // Unmapped address
    bus_read (8'h50, 8'h00);
    bus_write(8'h50, 8'hAA);
    bus_read(8'h00, 8'h10); bus_read(8'h21, 8'h11); bus_read(8'h22, 8'h00);
    bus_read(8'h23, 8'h12); bus_read(8'h24, 8'h02);

    // Invalid BCD above the limit wraps and carries
    bus_write(8'h21, 8'h5A);
    pulse_tick();
    bus_read(8'h21, 8'h00); bus_read(8'h22, 8'h01);

    // cs rises before the wr edge: phase abandoned
    addr_phase(8'h21);
    bus.ADin = 8'h37;
    clk(3); bus.wr = 1'b0;
    clk(3); bus.cs = 1'b1;
    clk(4); bus.wr = 1'b1;
    clk(4);
    bus_read(8'h21, 8'h00);

    // Reset in the middle of a read with oe high
    bus_write(8'h21, 8'h33);
    addr_phase(8'h21);
    clk(2);
    exp_q.push_back(8'h33);
    bus.rd = 1'b0;
    clk(5);
    #1 reset = 1'b0;
    #1;
    check8("async_reset_oe",    {7'd0, bus.oe},   8'h00);
    check8("async_reset_adout", bus.ADout,        8'hFF);
    check8("async_reset_busy",  {7'd0, bus.busy}, 8'h00);
    bus.rd = 1'b1; bus.cs = 1'b1; bus.ad = 1'b1;
    clk(3);
    reset = 1'b1;
    clk(3);
    bus_read(8'h21, 8'h00); bus_read(8'h22, 8'h00); bus_read(8'h23, 8'h00);
    bus_read(8'h24, 8'h01); bus_read(8'h00, 8'h00);

    clk(10);
    check8("reads_outstanding", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rtc_responder
`default_nettype wire
